// File: rtl/ks_add_4b.sv
// ---------------------------------------------------------------------------
// ks_add_4b
// Registered 4-bit Kogge-Stone parallel-prefix adder with carry-in and
// carry-out.  The prefix tree is built only from AND, XOR and inverter
// functions; OR is formed as an inverted AND of inverted inputs.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset, clears the sum register
//   k0..k3         operand A, k0 = LSB
//   t0..t3         operand B, t0 = LSB
//   cin            carry-in, weight 2^0
//   s0..s3         registered sum bits 0..3
//   s4             registered carry-out, weight 2^4
//
// Result S = {s4,s3,s2,s1,s0} = A + B + cin appears one clock after the
// operands are sampled.  The outputs come straight from flops.
// ---------------------------------------------------------------------------
module ks_add_4b (
  input  logic clk,
  input  logic rst_n,
  input  logic k0,
  input  logic k1,
  input  logic k2,
  input  logic k3,
  input  logic t0,
  input  logic t1,
  input  logic t2,
  input  logic t3,
  input  logic cin,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4
);

  // OR built from the available cells: a | b == ~(~a & ~b).
  function automatic logic or2(input logic a, input logic b);
    return ~((~a) & (~b));
  endfunction

  // Prefix combine of a (G,P) pair with the lower group's generate.
  function automatic logic gen_comb(input logic g_hi, input logic p_hi,
                                    input logic g_lo);
    return or2(g_hi, p_hi & g_lo);
  endfunction

  // Pre-processing: bitwise generate and propagate.
  logic g0, g1, g2, g3;
  logic p0, p1, p2, p3;

  assign g0 = k0 & t0;
  assign g1 = k1 & t1;
  assign g2 = k2 & t2;
  assign g3 = k3 & t3;

  assign p0 = k0 ^ t0;
  assign p1 = k1 ^ t1;
  assign p2 = k2 ^ t2;
  assign p3 = k3 ^ t3;

  // cin sits at position -1 as a generate.  Bit 0 is the only position
  // that can see it within span 1, so it is combined into bit 0 up front;
  // that keeps the tree at two levels over positions 0..3 while every
  // group generate still reaches down to position -1.
  logic g0c;
  assign g0c = gen_comb(g0, p0, cin);

  // Prefix level 1 (span 1).
  logic gl1_0, gl1_1, gl1_2, gl1_3;
  logic pl1_1, pl1_2, pl1_3;

  assign gl1_0 = g0c;
  assign gl1_1 = gen_comb(g1, p1, g0c);
  assign gl1_2 = gen_comb(g2, p2, g1);
  assign gl1_3 = gen_comb(g3, p3, g2);

  assign pl1_1 = p1 & p0;
  assign pl1_2 = p2 & p1;
  assign pl1_3 = p3 & p2;

  // Prefix level 2 (span 2).  Positions 0 and 1 are already complete
  // after level 1; positions 2 and 3 pick up the lower pair.
  logic c0, c1, c2, c3;

  assign c0 = gl1_0;
  assign c1 = gl1_1;
  assign c2 = gen_comb(gl1_2, pl1_2, gl1_0);
  assign c3 = gen_comb(gl1_3, pl1_3, gl1_1);

  // Post-processing: sum bits from propagate and the carry below.
  logic [4:0] sum_d;

  assign sum_d[0] = p0 ^ cin;
  assign sum_d[1] = p1 ^ c0;
  assign sum_d[2] = p2 ^ c1;
  assign sum_d[3] = p3 ^ c2;
  assign sum_d[4] = c3;

  // Output register bank: all five result bits are captured together.
  // Reset clears it immediately so no stale sum survives a reset pulse.
  logic [4:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 5'b00000;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign s0 = sum_q[0];
  assign s1 = sum_q[1];
  assign s2 = sum_q[2];
  assign s3 = sum_q[3];
  assign s4 = sum_q[4];

endmodule

// File: tb/tb_ks_add_4b.sv
// ---------------------------------------------------------------------------
// tb_ks_add_4b
// Self-checking bench for ks_add_4b.  Expected sums come from plain integer
// addition of the applied operands; each result is checked one cycle after
// its operands are sampled, plus asynchronous reset behaviour.
// ---------------------------------------------------------------------------
module tb_ks_add_4b;

  logic clk;
  logic rst_n;
  logic k0, k1, k2, k3;
  logic t0, t1, t2, t3;
  logic cin;
  logic s0, s1, s2, s3, s4;

  int errors;
  int checks;

  ks_add_4b dut (
    .clk  (clk),
    .rst_n(rst_n),
    .k0   (k0),
    .k1   (k1),
    .k2   (k2),
    .k3   (k3),
    .t0   (t0),
    .t1   (t1),
    .t2   (t2),
    .t3   (t3),
    .cin  (cin),
    .s0   (s0),
    .s1   (s1),
    .s2   (s2),
    .s3   (s3),
    .s4   (s4)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one operand set onto the scalar ports.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic c);
    {k3, k2, k1, k0} = a;
    {t3, t2, t1, t0} = b;
    cin = c;
  endtask

  // Compare the assembled output word against the expected value.
  task automatic checkOutput(input string tag, input logic [4:0] expected);
    logic [4:0] observed;
    observed = {s4, s3, s2, s1, s0};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed,
             expected);
    end
  endtask

  // Reference sum computed with ordinary integer arithmetic.
  function automatic logic [4:0] refSum(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic c);
    int total;
    total = int'(a) + int'(b) + int'(c);
    return total[4:0];
  endfunction

  // Apply operands, wait for the sampling edge, then check shortly after.
  task automatic stepCheck(input string tag, input logic [3:0] a,
                           input logic [3:0] b, input logic c);
    applyStimulus(a, b, c);
    @(posedge clk);
    #1;
    checkOutput(tag, refSum(a, b, c));
  endtask

  initial begin
    logic [3:0] ra, rb;
    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    applyStimulus(4'hF, 4'hF, 1'b1);

    // Reset asserted with all-ones inputs: outputs clear without an edge.
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_async", 5'd0);
    @(posedge clk);
    #1 checkOutput("reset_held_edge", 5'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("post_reset_31", 5'd31);

    // Directed boundary and mixed cases, back-to-back.
    stepCheck("zero", 4'h0, 4'h0, 1'b0);
    stepCheck("propagate_chain", 4'hF, 4'h0, 1'b1);
    stepCheck("mixed_15", 4'h5, 4'hA, 1'b0);
    stepCheck("mixed_16", 4'h9, 4'h7, 1'b0);
    stepCheck("all_ones_cin", 4'hF, 4'hF, 1'b1);
    stepCheck("propagate_alt", 4'h6, 4'h9, 1'b1);
    stepCheck("max_no_cin", 4'hF, 4'hF, 1'b0);

    // Random sweep: each pair with cin = 0 then cin = 1, every cycle.
    for (int i = 0; i < 256; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      stepCheck("rand_cin0", ra, rb, 1'b0);
      stepCheck("rand_cin1", ra, rb, 1'b1);
    end

    // Mid-stream reset: known nonzero value, then a pulse between edges.
    stepCheck("pre_pulse", 4'hC, 4'h7, 1'b1);
    applyStimulus(4'h3, 4'h8, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("pulse_async_clear", 5'd0);
    applyStimulus(4'hE, 4'hD, 1'b1);
    @(posedge clk);
    #1 checkOutput("pulse_held_edge", 5'd0);
    applyStimulus(4'hA, 4'h6, 1'b1);
    #2 rst_n = 1'b1;
    #1 checkOutput("pulse_still_zero", 5'd0);
    @(posedge clk);
    #1 checkOutput("post_pulse_first", refSum(4'hA, 4'h6, 1'b1));
    stepCheck("post_pulse_next", 4'h2, 4'h3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
